// File: rtl/mem_arb_pkg.sv
// Shared types for the main-memory arbiter: FSM states, requester ids, offset-bit helper.
// Pure declarations, no logic.
package mem_arb_pkg;

   typedef enum logic [2:0] {IDLE, WAIT, XFER, LAST, DONE} arb_state_t;

   typedef enum logic {REQ_IC, REQ_DC} requester_t;

   localparam int WORD_OFS_BITS = 2;

   // Number of low address bits cleared to form a block base address.
   function automatic int offset_bits(input int block_words);
      return $clog2(block_words) + WORD_OFS_BITS;
   endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: the requester not granted last wins a tie.
// Combinational, zero latency; no backpressure of its own.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic       req_ic,
   input  logic       req_dc,
   input  requester_t last_gnt,
   output requester_t gnt,
   output logic       gnt_vld
);

   always_comb begin
      gnt = REQ_IC;
      if (req_ic && req_dc) begin
         gnt = (last_gnt == REQ_IC) ? REQ_DC : REQ_IC;
      end else if (req_dc) begin
         gnt = REQ_DC;
      end
   end

   assign gnt_vld = req_ic | req_dc;

endmodule

// File: rtl/mem_arbiter.sv
// Serialises I-cache and D-cache block transfers onto one memory; first beat after MEM_LATENCY waits,
// one beat per cycle; requests are held as levels until the owner's done pulse.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int BLOCK_WORDS = 4,
   parameter int MEM_LATENCY = 2,
   localparam int BW         = $clog2(BLOCK_WORDS)
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ic_req,
   input  logic [ADDR_WIDTH-1:0] ic_addr,
   output logic [DATA_WIDTH-1:0] ic_rdata,
   output logic                  ic_rvalid,
   output logic [BW-1:0]         ic_beat,
   output logic                  ic_done,
   input  logic                  dc_req,
   input  logic                  dc_we,
   input  logic [ADDR_WIDTH-1:0] dc_addr,
   input  logic [DATA_WIDTH-1:0] dc_wdata,
   output logic                  dc_wready,
   output logic [DATA_WIDTH-1:0] dc_rdata,
   output logic                  dc_rvalid,
   output logic [BW-1:0]         dc_beat,
   output logic                  dc_done,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam int OFS   = offset_bits(BLOCK_WORDS);
   localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [LAT_W-1:0]      LAT_INIT  = (MEM_LATENCY > 0) ? LAT_W'(MEM_LATENCY - 1) : '0;
   localparam logic [BW-1:0]         LAST_BEAT = BW'(BLOCK_WORDS - 1);
   localparam logic [ADDR_WIDTH-1:0] BASE_MASK = ~((ADDR_WIDTH'(1) << OFS) - ADDR_WIDTH'(1));

   arb_state_t            state;
   requester_t            owner;
   requester_t            last_gnt;
   requester_t            gnt;
   logic                  gnt_vld;
   logic                  we_q;
   logic [ADDR_WIDTH-1:0] base_q;
   logic [BW-1:0]         beat_cnt;
   logic [LAT_W-1:0]      lat_cnt;
   logic                  rd_vld_q;
   logic [BW-1:0]         rd_beat_q;

   rr_arb2 u_rr_arb2 (
      .req_ic   (ic_req),
      .req_dc   (dc_req),
      .last_gnt (last_gnt),
      .gnt      (gnt),
      .gnt_vld  (gnt_vld)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         owner     <= REQ_IC;
         last_gnt  <= REQ_IC;
         we_q      <= 1'b0;
         base_q    <= '0;
         beat_cnt  <= '0;
         lat_cnt   <= '0;
         rd_vld_q  <= 1'b0;
         rd_beat_q <= '0;
      end else begin
         // Memory returns read data one cycle after the strobe, so valid/beat trail XFER by one stage.
         rd_vld_q  <= (state == XFER) && !we_q;
         rd_beat_q <= beat_cnt;
         case (state)
            IDLE: begin
               if (gnt_vld) begin
                  owner    <= gnt;
                  we_q     <= (gnt == REQ_DC) && dc_we;
                  base_q   <= ((gnt == REQ_DC) ? dc_addr : ic_addr) & BASE_MASK;
                  beat_cnt <= '0;
                  if (MEM_LATENCY == 0) begin
                     state <= XFER;
                  end else begin
                     state   <= WAIT;
                     lat_cnt <= LAT_INIT;
                  end
               end
            end
            WAIT: begin
               if (lat_cnt == '0) state <= XFER;
               else               lat_cnt <= lat_cnt - 1'b1;
            end
            XFER: begin
               if (beat_cnt == LAST_BEAT) begin
                  beat_cnt <= '0;
                  state    <= we_q ? DONE : LAST;
               end else begin
                  beat_cnt <= beat_cnt + 1'b1;
               end
            end
            LAST: state <= DONE;
            DONE: begin
               last_gnt <= owner;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   logic xfer, wr_beat, rd_ic, rd_dc;
   assign xfer    = (state == XFER);
   assign wr_beat = xfer && we_q;
   assign rd_ic   = rd_vld_q && (owner == REQ_IC);
   assign rd_dc   = rd_vld_q && (owner == REQ_DC);

   assign mem_en    = xfer;
   assign mem_we    = wr_beat;
   assign mem_addr  = xfer ? (base_q | (ADDR_WIDTH'(beat_cnt) << 2)) : '0;
   assign mem_wdata = wr_beat ? dc_wdata : '0;

   assign ic_rvalid = rd_ic;
   assign ic_rdata  = rd_ic ? mem_rdata : '0;
   assign ic_beat   = rd_ic ? rd_beat_q : '0;
   assign ic_done   = (state == DONE) && (owner == REQ_IC);

   // During a write-back dc_beat tells the D-cache which word to present on dc_wdata.
   assign dc_wready = wr_beat;
   assign dc_rvalid = rd_dc;
   assign dc_rdata  = rd_dc ? mem_rdata : '0;
   assign dc_beat   = rd_dc ? rd_beat_q : (wr_beat ? beat_cnt : '0);
   assign dc_done   = (state == DONE) && (owner == REQ_DC);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed transfers push expected beats, a monitor pops and compares.
module tb_mem_arbiter;

   logic        clk, rst, load;
   int          cyc;

   logic        ic_req, dc_req, dc_we;
   logic [31:0] ic_addr, dc_addr, dc_wdata, ic_rdata, dc_rdata;
   logic        ic_rvalid, ic_done, dc_wready, dc_rvalid, dc_done;
   logic [1:0]  ic_beat, dc_beat;
   logic        mem_en, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   logic        ic_req_z, dc_req_z, dc_we_z;
   logic [31:0] ic_addr_z, dc_addr_z, dc_wdata_z, ic_rdata_z, dc_rdata_z;
   logic        ic_rvalid_z, ic_done_z, dc_wready_z, dc_rvalid_z, dc_done_z;
   logic [1:0]  ic_beat_z, dc_beat_z;
   logic        mem_en_z, mem_we_z;
   logic [31:0] mem_addr_z, mem_wdata_z, mem_rdata_z;

   logic [31:0] mem   [1024];
   logic [31:0] mem_z [1024];
   logic [31:0] wbuf  [4];

   typedef struct {
      int          cyc;
      logic [31:0] a;
      logic [31:0] d;
      logic [1:0]  f;
   } ev_t;

   ev_t mem_q[$], icr_q[$], dcr_q[$], icd_q[$], dcd_q[$], zmem_q[$], zr_q[$], zd_q[$];
   int  n_cmp, n_bad;

   mem_arbiter #(.MEM_LATENCY(2)) u_dut (
      .clk(clk), .rst(rst),
      .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_rvalid(ic_rvalid),
      .ic_beat(ic_beat), .ic_done(ic_done),
      .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
      .dc_wready(dc_wready), .dc_rdata(dc_rdata), .dc_rvalid(dc_rvalid),
      .dc_beat(dc_beat), .dc_done(dc_done),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   mem_arbiter #(.MEM_LATENCY(0)) u_dut_z (
      .clk(clk), .rst(rst),
      .ic_req(ic_req_z), .ic_addr(ic_addr_z), .ic_rdata(ic_rdata_z), .ic_rvalid(ic_rvalid_z),
      .ic_beat(ic_beat_z), .ic_done(ic_done_z),
      .dc_req(dc_req_z), .dc_we(dc_we_z), .dc_addr(dc_addr_z), .dc_wdata(dc_wdata_z),
      .dc_wready(dc_wready_z), .dc_rdata(dc_rdata_z), .dc_rvalid(dc_rvalid_z),
      .dc_beat(dc_beat_z), .dc_done(dc_done_z),
      .mem_en(mem_en_z), .mem_we(mem_we_z), .mem_addr(mem_addr_z), .mem_wdata(mem_wdata_z),
      .mem_rdata(mem_rdata_z)
   );

   // D-cache write-back model: presents the word selected by dc_beat.
   assign dc_wdata = wbuf[dc_beat];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] pat(input int i);
      if (i >= 'h40 && i <= 'h43) return 32'hA0 + 32'(i - 'h40);
      return 32'hC000_0000 + 32'(i);
   endfunction

   always @(posedge clk) begin
      if (load) begin
         for (int i = 0; i < 1024; i++) begin
            mem[i]   <= pat(i);
            mem_z[i] <= pat(i);
         end
      end else begin
         if (mem_en) begin
            if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[11:2]];
         end
         if (mem_en_z) begin
            if (mem_we_z) mem_z[mem_addr_z[11:2]] <= mem_wdata_z;
            else          mem_rdata_z <= mem_z[mem_addr_z[11:2]];
         end
      end
   end

   function automatic logic [159:0] all_outs();
      return 160'({ic_rdata, ic_rvalid, ic_beat, ic_done, dc_wready, dc_rdata, dc_rvalid,
                   dc_beat, dc_done, mem_en, mem_we, mem_addr, mem_wdata});
   endfunction

   task automatic cmp(input string nm, input logic [159:0] act, input logic [159:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: actual %h required %h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic unexp(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: unexpected at cycle %0d", nm, cyc);
   endtask

   task automatic run_monitor();
      ev_t e;
      forever begin
         @(negedge clk);
         if (mem_en) begin
            if (mem_q.size() == 0) unexp("mem_en");
            else begin
               e = mem_q.pop_front();
               cmp("mem_beat", {cyc, mem_addr, mem_wdata, 30'b0, mem_we, dc_wready},
                   {e.cyc, e.a, e.d, 30'b0, e.f});
            end
         end else if (mem_we || dc_wready) unexp("we_outside_xfer");
         if (ic_rvalid) begin
            if (icr_q.size() == 0) unexp("ic_rvalid");
            else begin
               e = icr_q.pop_front();
               cmp("ic_rbeat", {cyc, 30'b0, ic_beat, ic_rdata}, {e.cyc, e.a, e.d});
            end
         end
         if (dc_rvalid) begin
            if (dcr_q.size() == 0) unexp("dc_rvalid");
            else begin
               e = dcr_q.pop_front();
               cmp("dc_rbeat", {cyc, 30'b0, dc_beat, dc_rdata}, {e.cyc, e.a, e.d});
            end
         end
         if (ic_done) begin
            if (icd_q.size() == 0) unexp("ic_done");
            else begin e = icd_q.pop_front(); cmp("ic_done_cycle", cyc, e.cyc); end
         end
         if (dc_done) begin
            if (dcd_q.size() == 0) unexp("dc_done");
            else begin e = dcd_q.pop_front(); cmp("dc_done_cycle", cyc, e.cyc); end
         end
         if (mem_en_z) begin
            if (zmem_q.size() == 0) unexp("z_mem_en");
            else begin
               e = zmem_q.pop_front();
               cmp("z_mem_beat", {cyc, mem_addr_z, 31'b0, mem_we_z}, {e.cyc, e.a, 31'b0, e.f[1]});
            end
         end
         if (ic_rvalid_z) begin
            if (zr_q.size() == 0) unexp("z_ic_rvalid");
            else begin
               e = zr_q.pop_front();
               cmp("z_ic_rbeat", {cyc, 30'b0, ic_beat_z, ic_rdata_z}, {e.cyc, e.a, e.d});
            end
         end
         if (ic_done_z) begin
            if (zd_q.size() == 0) unexp("z_ic_done");
            else begin e = zd_q.pop_front(); cmp("z_ic_done_cycle", cyc, e.cyc); end
         end
         if (dc_rvalid_z || dc_done_z || dc_wready_z) unexp("z_dc_port");
      end
   endtask

   // port: 0 = I-cache, 1 = D-cache, 2 = I-cache of the zero-latency instance.
   task automatic exp_read(input int port, input int t0, input int lat, input logic [31:0] base,
                           input logic [31:0] d0, input logic [31:0] step);
      ev_t e;
      for (int k = 0; k < 4; k++) begin
         e.cyc = t0 + lat + 1 + k; e.a = base + 32'(4 * k); e.d = '0; e.f = 2'b00;
         if (port == 2) zmem_q.push_back(e); else mem_q.push_back(e);
         e.cyc = t0 + lat + 2 + k; e.a = 32'(k); e.d = d0 + step * 32'(k);
         if (port == 0) icr_q.push_back(e); else if (port == 1) dcr_q.push_back(e); else zr_q.push_back(e);
      end
      e.cyc = t0 + lat + 6; e.a = '0; e.d = '0;
      if (port == 0) icd_q.push_back(e); else if (port == 1) dcd_q.push_back(e); else zd_q.push_back(e);
   endtask

   task automatic exp_write(input int t0, input logic [31:0] base, input logic [31:0] d0,
                            input logic [31:0] step);
      ev_t e;
      for (int k = 0; k < 4; k++) begin
         wbuf[k] = d0 + step * 32'(k);
         e.cyc = t0 + 3 + k; e.a = base + 32'(4 * k); e.d = wbuf[k]; e.f = 2'b11;
         mem_q.push_back(e);
      end
      e.cyc = t0 + 7; e.a = '0; e.d = '0; e.f = 2'b00;
      dcd_q.push_back(e);
   endtask

   task automatic wait_done(input int port);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         seen = (port == 0) ? ic_done : (port == 1) ? dc_done : ic_done_z;
      end
      if (!seen) begin
         n_cmp++;
         n_bad++;
         $display("FAIL done_timeout: port %0d saw no done within 60 cycles", port);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   int t0;

   initial begin
      rst = 1'b1; load = 1'b1; cyc = 0; n_cmp = 0; n_bad = 0;
      ic_req = 0; ic_addr = '0; dc_req = 0; dc_we = 0; dc_addr = '0;
      ic_req_z = 0; ic_addr_z = '0; dc_req_z = 0; dc_we_z = 0; dc_addr_z = '0; dc_wdata_z = '0;
      for (int k = 0; k < 4; k++) wbuf[k] = '0;
      fork run_monitor(); join_none
      #2 rst = 1'b0;
      #1 cmp("reset_outputs", all_outs(), '0);
      repeat (3) @(posedge clk);
      load = 1'b0;
      @(negedge clk) rst = 1'b1;
      next_cycle();

      // Ties from reset: D, I, D, I with both requests held.
      t0 = cyc;
      ic_req = 1; ic_addr = 32'h300; dc_req = 1; dc_we = 0; dc_addr = 32'h400;
      exp_read(1, t0,      2, 32'h400, 32'hC000_0100, 1);
      exp_read(0, t0 + 9,  2, 32'h300, 32'hC000_00C0, 1);
      exp_read(1, t0 + 18, 2, 32'h400, 32'hC000_0100, 1);
      exp_read(0, t0 + 27, 2, 32'h300, 32'hC000_00C0, 1);
      wait_done(1); wait_done(0); wait_done(1);
      dc_req = 0;
      wait_done(0);
      ic_req = 0;

      next_cycle();
      t0 = cyc; ic_req = 1; ic_addr = 32'h104;
      exp_read(0, t0, 2, 32'h100, 32'hA0, 1);
      wait_done(0);
      ic_req = 0;

      next_cycle();
      t0 = cyc; dc_req = 1; dc_we = 1; dc_addr = 32'h200;
      exp_write(t0, 32'h200, 32'h11, 32'h11);
      wait_done(1);
      dc_req = 0; dc_we = 0;

      next_cycle();
      t0 = cyc; dc_req = 1; dc_addr = 32'h208;
      exp_read(1, t0, 2, 32'h200, 32'h11, 32'h11);
      wait_done(1);
      dc_req = 0;

      // Request dropped and address changed mid-XFER: captured base still used.
      next_cycle();
      t0 = cyc; ic_req = 1; ic_addr = 32'h184;
      exp_read(0, t0, 2, 32'h180, 32'hC000_0060, 1);
      repeat (4) next_cycle();
      ic_req = 0; ic_addr = 32'hFFC;
      wait_done(0);

      // Reset during XFER beat 2.
      next_cycle();
      t0 = cyc; ic_req = 1; ic_addr = 32'h100;
      exp_read(0, t0, 2, 32'h100, 32'hA0, 1);
      repeat (5) next_cycle();
      rst = 1'b0;
      #1 cmp("midburst_reset_outputs", all_outs(), '0);
      mem_q.delete(); icr_q.delete(); icd_q.delete();
      ic_req = 0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      next_cycle();
      t0 = cyc; ic_req = 1; ic_addr = 32'h104;
      exp_read(0, t0, 2, 32'h100, 32'hA0, 1);
      wait_done(0);
      ic_req = 0;

      // Zero-latency instance.
      next_cycle();
      t0 = cyc; ic_req_z = 1; ic_addr_z = 32'h104;
      exp_read(2, t0, 0, 32'h100, 32'hA0, 1);
      wait_done(2);
      ic_req_z = 0;

      repeat (6) next_cycle();
      cmp("left_mem",  mem_q.size(),  0);
      cmp("left_icr",  icr_q.size(),  0);
      cmp("left_dcr",  dcr_q.size(),  0);
      cmp("left_icd",  icd_q.size(),  0);
      cmp("left_dcd",  dcd_q.size(),  0);
      cmp("left_zmem", zmem_q.size(), 0);
      cmp("left_zr",   zr_q.size(),   0);
      cmp("left_zd",   zd_q.size(),   0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates a single backing main memory between the instruction-cache refill port and the data-cache refill/write-back port in the cached pipeline. It serialises block transfers, models a fixed memory access latency, and sequences each transfer beat by beat. The per-port `done` pulses release the caches' stall logic. The block sits below both caches and above the backing SRAM.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: byte address width.
- `DATA_WIDTH`, 32: word width.
- `BLOCK_WORDS`, 4: words per cache block; a power of two, at least 2.
- `MEM_LATENCY`, 2: wait cycles before the first beat; 0 is legal.

Ports (`BW` = $clog2(`BLOCK_WORDS`)):
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-low reset.
- `ic_req` in 1: I-cache block read request; level, held until `ic_done`.
- `ic_addr` in `ADDR_WIDTH`: I-cache block address; offset bits are ignored.
- `ic_rdata` out `DATA_WIDTH`: read beat data.
- `ic_rvalid` out 1: `ic_rdata` is valid this cycle.
- `ic_beat` out `BW`: word index of the current beat.
- `ic_done` out 1: one-cycle pulse when the transfer completes.
- `dc_req` in 1: D-cache request; level, held until `dc_done`.
- `dc_we` in 1: 1 = block write-back, 0 = refill.
- `dc_addr` in `ADDR_WIDTH`: D-cache block address.
- `dc_wdata` in `DATA_WIDTH`: write word for the beat given by `dc_beat`.
- `dc_wready` out 1: the write word is consumed this cycle.
- `dc_rdata` out `DATA_WIDTH`: read beat data.
- `dc_rvalid` out 1: `dc_rdata` is valid this cycle.
- `dc_beat` out `BW`: word index of the current beat.
- `dc_done` out 1: one-cycle pulse when the transfer completes.
- `mem_en` out 1: memory access strobe.
- `mem_we` out 1: write strobe.
- `mem_addr` out `ADDR_WIDTH`: word-aligned memory address.
- `mem_wdata` out `DATA_WIDTH`: write data.
- `mem_rdata` in `DATA_WIDTH`: synchronous read data, valid the cycle after a read strobe.

## Operation
- FSM states: IDLE, WAIT, XFER, LAST, DONE.
- IDLE: if any request is high, grant one requester and go to WAIT, or straight to XFER if `MEM_LATENCY`=0.
  - On the grant, capture the owner, `we` (forced to 0 for the I-cache) and the block base address, which is the address with its low `BW`+2 bits cleared.
- WAIT: a latency counter loads `MEM_LATENCY`-1 and counts down; on reaching 0, go to XFER.
- XFER: one beat per cycle for `BLOCK_WORDS` cycles; the beat counter runs 0..`BLOCK_WORDS`-1.
  - `mem_en`=1 every XFER cycle.
  - `mem_we`=captured `we`.
  - `mem_addr`=base | (beat<<2).
  - Writes: `mem_wdata`=`dc_wdata` and `dc_wready`=1.
- The last beat goes to LAST for a read, or directly to DONE for a write.
- LAST: the final read word returns; no memory strobe. Go to DONE.
- Read data path: `rvalid` and `beat` are the beat and valid of the previous cycle, delayed one register stage, to the owner only.
  - `rdata` is passed through from `mem_rdata` combinationally.
- DONE: pulse the owner's `done`; record the owner as last-granted; go to IDLE.
- Arbitration: round-robin on simultaneous requests, where the requester not granted last wins. A lone request always wins.
  - After reset, last-granted = I-cache, so the D-cache wins the first tie.
- A request is sampled only in IDLE. Requests arriving mid-transfer wait. A requester dropping `req` mid-transfer has no effect; the transfer completes.
- Address and `we` changes after the grant are ignored.
- Non-owner outputs stay 0 throughout.
- Reset, at any time including mid-burst: state returns to IDLE, counters clear to 0, last-granted is set to I-cache, and every output is 0. No partial `done` is issued.

## Timing
- Moore outputs decoded from registered state and counters, plus the `rdata` pass-through.
- Read with L=`MEM_LATENCY`, N=`BLOCK_WORDS`: request sampled in IDLE at cycle t0.
  - WAIT occupies t1..tL.
  - XFER occupies tL+1..tL+N.
  - Beat k's `rvalid` is at tL+2+k.
  - LAST is tL+N+1, coinciding with the final `rvalid`.
  - DONE is tL+N+2, with the `done` pulse.
  - IDLE resumes at tL+N+3.
- Write: XFER occupies tL+1..tL+N; DONE is at tL+N+1.
- Back-to-back: a request pending during DONE is sampled in the IDLE cycle immediately after. One idle cycle between transfers is required.
- Beat counter wraps only via the state exit; it is never observed above N-1.

## Structure
- Package `mem_arb_pkg` holds:
  - the `arb_state_t` enum (IDLE, WAIT, XFER, LAST, DONE);
  - the `requester_t` enum (REQ_IC, REQ_DC);
  - the helper constant for the offset-bit count.
- One sub-module, `rr_arb2`: a two-way round-robin arbiter that takes the two requests and last-granted and returns the grant. It is purely combinational; the last-granted register lives in the top level.

## Test plan
- Reset, then `ic_req` at `ic_addr`=0x0000_0104, L=2, N=4, with the memory preloaded so word i holds 0xA0+i.
  - `mem_addr` is 0x100, 0x104, 0x108, 0x10C in t3..t6.
  - `ic_rvalid` is high t4..t7 with data 0xA0..0xA3 on beats 0..3.
  - `ic_done` pulses at t8.
- `dc_req` with `dc_we`=1 at 0x200, `dc_wdata`=0x11,0x22,0x33,0x44 per beat.
  - `dc_wready` and `mem_we` are high t3..t6.
  - A readback of memory matches.
  - `dc_done` pulses at t7; `dc_rvalid` stays 0.
- Both requests high from reset: the D-cache is granted first, and the I-cache is granted in the IDLE cycle after `dc_done`.
  - Repeating ties alternate between the two ports.
- `MEM_LATENCY`=0: XFER starts at t1; the read `done` pulses at t1+N+1.
- Assert `rst` low during XFER beat 2: all outputs are 0 immediately.
  - After release, a fresh `ic_req` completes normally with no stale `done`.
- The I-cache drops `ic_req` mid-XFER and changes `ic_addr`: all 4 beats still complete from the captured base.
